// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit paths.
//   DEF_DEPTH  : default receive FIFO depth (entries)
//   DEF_OVS    : default baud ticks per serial bit
//   byte_t     : one serial data byte
//   rx_state_t : receive framing FSM states
//   parity_of  : even-parity bit of a byte (XOR of all bits)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_OVS   = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic parity_of(input byte_t b);
    return ^b;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
// First-word fall-through receive FIFO.
// Parameters:
//   DEPTH   : number of entries, power of two, at least 2
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-low reset
//   push    : write din this cycle
//   pop     : advance the head this cycle (ignored while empty)
//   din     : byte to write
//   dout    : current head byte
//   valid   : FIFO non-empty
//   full    : FIFO holds DEPTH entries
//   overrun : one-cycle pulse after a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  push,
  input  logic  pop,
  input  byte_t din,
  output byte_t dout,
  output logic  valid,
  output logic  full,
  output logic  overrun
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  byte_t       mem [DEPTH];
  logic        empty;
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = ~empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop while full frees the slot this push needs; a pop while empty is void.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      overrun <= push & full & ~do_pop;
    end
  end

endmodule

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
// UART receive path: 2-flop line synchronizer, oversampled framing FSM
// (start / 8 data bits LSB first / optional even parity / stop) and a
// first-word fall-through receive FIFO.
// Build option: define RX_PARITY_EN to expect an even-parity bit after the
// data bits; otherwise o_parity_err is tied low.
// Parameters:
//   DEPTH        : FIFO entries, power of two, at least 2
//   OVS          : baud ticks per bit, even, at least 4
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : asynchronous active-low reset
//   i_baud       : single-cycle tick at OVS times the bit rate
//   i_rx         : asynchronous serial line, idles high
//   i_read       : pop the FIFO head
//   o_data       : FIFO head byte
//   o_valid      : FIFO non-empty
//   o_full       : FIFO full
//   o_frame_err  : one-cycle pulse on a bad stop bit
//   o_overrun    : one-cycle pulse when a good byte is dropped (FIFO full)
//   o_parity_err : one-cycle pulse on a parity mismatch
// -----------------------------------------------------------------------------
module receiver
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int OVS   = DEF_OVS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_baud,
  input  logic       i_rx,
  input  logic       i_read,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_full,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int                TICK_W    = $clog2(OVS);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVS - 1);

  logic              rx_sync_p0;
  logic              rx_sync_p1;
  logic              rx;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  byte_t             shift_p1;
  logic              half_done;
  logic              bit_done;
  logic              push;
  logic              frame_err_d;
  logic              frame_err_p1;

  // ---- stage p0/p1: line synchronizer (idles high) ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= i_rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx = rx_sync_p1;

  // Mid-start-bit point and full bit period, both only on a baud tick.
  assign half_done = i_baud && (tick_cnt == HALF_LAST);
  assign bit_done  = i_baud && (tick_cnt == FULL_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_baud && !rx) state_nxt = START;
      START:   if (half_done) state_nxt = rx ? IDLE : DATA;
`ifdef RX_PARITY_EN
      DATA:    if (bit_done && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY:  if (bit_done) state_nxt = STOP;
`else
      DATA:    if (bit_done && bit_cnt == 3'd7) state_nxt = STOP;
      PARITY:  state_nxt = IDLE;
`endif
      STOP:    if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RX_PARITY_EN
  logic parity_bad;
  logic parity_err_d;
  logic parity_err_p1;
`endif

  // A bad stop bit wins over a parity mismatch; only one error pulses.
  always_comb begin
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (state == STOP && bit_done) begin
      if (!rx) frame_err_d = 1'b1;
`ifdef RX_PARITY_EN
      else if (parity_bad) parity_err_d = 1'b1;
`endif
      else push = 1'b1;
    end
  end

  // ---- stage p1: bit counters, data shift register, error pulses ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_p1     <= '0;
      frame_err_p1 <= 1'b0;
    end else begin
      if (i_baud) begin
        if (state == IDLE || (state == START && half_done) || bit_done) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (bit_done) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == DATA && bit_done) begin
        shift_p1 <= {rx, shift_p1[7:1]};
      end
      frame_err_p1 <= frame_err_d;
    end
  end

`ifdef RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      parity_bad    <= 1'b0;
      parity_err_p1 <= 1'b0;
    end else begin
      if (state == PARITY && bit_done) begin
        parity_bad <= parity_of(shift_p1) ^ rx;
      end
      parity_err_p1 <= parity_err_d;
    end
  end

  assign o_parity_err = parity_err_p1;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_frame_err = frame_err_p1;

  rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (push),
    .pop     (i_read),
    .din     (shift_p1),
    .dout    (o_data),
    .valid   (o_valid),
    .full    (o_full),
    .overrun (o_overrun)
  );

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter DEPTH, 8, receive FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter OVS, 16, baud-tick count per bit; SHALL be even, minimum 4.
REQ-003 Port i_clk  input  1  sole clock; all state SHALL be rising-edge triggered.
REQ-004 Port i_rst  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 Port i_baud  input  1  single-cycle tick at OVS times the bit rate.
REQ-006 Port i_rx  input  1  asynchronous serial line; idles high.
REQ-007 Port i_read  input  1  pop request for the FIFO head.
REQ-008 Port o_data  output  8  FIFO head byte, first-word fall-through.
REQ-009 Port o_valid  output  1  high while the FIFO is non-empty.
REQ-010 Port o_full  output  1  high while the FIFO holds DEPTH entries.
REQ-011 Port o_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-012 Port o_overrun  output  1  one-cycle pulse when a good byte is dropped.
REQ-013 Port o_parity_err  output  1  one-cycle pulse on a parity mismatch.

Function
REQ-014 i_rx SHALL pass through a 2-flop synchronizer before any use; the synchronizer SHALL reset to 1.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 The tick counter and bit counter SHALL advance only on cycles where i_baud=1.
REQ-017 IDLE->START SHALL occur on the first tick where the synchronized rx=0; the tick counter SHALL clear.
REQ-018 In START, after OVS/2 ticks, rx=0 SHALL go to DATA; rx=1 SHALL be treated as a glitch and return to IDLE with nothing logged.
REQ-019 In DATA, rx SHALL be sampled every OVS ticks; 8 samples SHALL be taken, LSB first, into a shift register.
REQ-020 After the 8th sample, the FSM SHALL go to PARITY if RX_PARITY_EN is defined, else to STOP.
REQ-021 In STOP, after OVS ticks, rx is sampled. rx=1 SHALL push the byte. rx=0 SHALL pulse o_frame_err and discard the byte. Either outcome SHALL return to IDLE.
REQ-022 Push latency: the byte SHALL be visible on o_data with o_valid=1 on the cycle after the stop sample, if the FIFO was empty.
REQ-023 Pop: i_read=1 with o_valid=1 SHALL advance the head on the next edge; i_read with an empty FIFO SHALL be ignored.
REQ-024 Full: a push with o_full=1 and no pop SHALL drop the byte and pulse o_overrun; FIFO contents SHALL be unchanged.
REQ-025 Simultaneous push and pop while full SHALL accept both; the count SHALL stay DEPTH.
REQ-026 Simultaneous push and pop while empty SHALL perform the push only.
REQ-027 Pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL derive from the MSB plus pointer equality.
REQ-028 Back-to-back frames SHALL be received without loss; a start edge is accepted on the tick after the stop sample.

Reset
REQ-029 Reset SHALL set: state=IDLE, counters=0, pointers=0, FIFO storage=0, o_data=0, o_valid=0, o_full=0, and all error pulses=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; no partial byte SHALL ever be pushed.

Configuration
REQ-031 Macro RX_PARITY_EN defined: the PARITY state SHALL sample one even-parity bit at OVS ticks. A mismatch SHALL pulse o_parity_err and discard the byte after STOP. A frame error SHALL take precedence, with one pulse only.
REQ-032 Macro RX_PARITY_EN undefined: the PARITY state SHALL be unreachable, and o_parity_err SHALL be tied to 0.

Structure
REQ-033 Package uart_pkg SHALL hold the rx state enum, the default DEPTH and OVS values, and the byte typedef; the package SHALL be shared with the transmit path.
REQ-034 The FIFO SHALL be a sub-module rx_fifo (parameter DEPTH; ports push, pop, din, dout, valid, full, overrun).

Verification
REQ-035 Frame 0x55 at OVS=16 -> o_data=0x55 and o_valid=1 exactly 1 cycle after the stop sample.
REQ-036 A 3-tick low glitch on idle rx -> no push and no error pulses; the FSM returns to IDLE.
REQ-037 Frame 0xA3 with stop bit=0 -> o_frame_err pulses once; o_valid stays 0.
REQ-038 DEPTH+1 frames (0x01..0x09) with no reads -> o_full=1 after 8; o_overrun pulses on the 9th; reads return 0x01..0x08 in order.
REQ-039 FIFO full with i_read held during the stop sample of frame 0x7E -> count stays 8; 0x7E becomes the last entry.
REQ-040 RX_PARITY_EN defined, frame 0x0F with parity bit=1 -> o_parity_err pulses once and the byte is discarded; parity bit=0 -> 0x0F is pushed.
